// File: rtl/cc_seq_if.sv
// Serial score stream in, ranked id stream out.
// master drives scores and out_ready; slave is the sequencer.
interface cc_seq_if;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_score;
  logic [2:0] in_opt;
  logic [1:0] in_a;
  logic [2:0] in_b;
  logic       out_valid;
  logic       out_ready;
  logic [2:0] out_id;
  logic [2:0] out_result;
  logic       out_last;

  modport master (
    output in_valid, in_score, in_opt, in_a, in_b,
    output out_ready,
    input  in_ready, out_valid, out_id,
    input  out_result, out_last
  );

  modport slave (
    input  in_valid, in_score, in_opt, in_a, in_b,
    input  out_ready,
    output in_ready, out_valid, out_id,
    output out_result, out_last
  );
endinterface

// File: rtl/cc_seq_ctrl.sv
// Frame sequencer around the combinational CC ranking core.
// Optional frame abort on LOAD gaps: define CC_SEQ_ABORT_EN.
module cc_seq_ctrl #(
  parameter int EXEC_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  cc_seq_if.slave     bus,
  output logic [27:0] cc_s_flat,
  output logic [2:0]  cc_opt,
  output logic [1:0]  cc_a,
  output logic [2:0]  cc_b,
  input  logic [20:0] cc_id_flat,
  input  logic [2:0]  cc_out,
  output logic        abort_err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_EXEC,
    S_DRAIN
  } state_t;

  localparam logic [3:0] LP_EXEC_LAST =
    4'(EXEC_CYCLES - 1);

  state_t           r_state;
  logic [3:0]       r_cnt;
  logic [2:0]       r_rank;
  logic [6:0][3:0]  r_s;
  logic [2:0]       r_opt;
  logic [1:0]       r_a;
  logic [2:0]       r_b;
  logic [6:0][2:0]  r_ids;
  logic [2:0]       r_res;
  logic             r_in_ready;
  logic             r_out_valid;
  logic [2:0]       r_out_id;
  logic             r_out_last;
`ifdef CC_SEQ_ABORT_EN
  logic             r_abort;
`endif

  logic       w_acc;
  logic       w_hs;
  logic [2:0] w_rank_nxt;

  assign w_acc      = bus.in_valid & r_in_ready;
  assign w_hs       = r_out_valid & bus.out_ready;
  assign w_rank_nxt = r_rank + 3'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_rank      <= '0;
      r_s         <= '0;
      r_opt       <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_ids       <= '0;
      r_res       <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_out_id    <= '0;
      r_out_last  <= 1'b0;
`ifdef CC_SEQ_ABORT_EN
      r_abort     <= 1'b0;
`endif
    end else begin
`ifdef CC_SEQ_ABORT_EN
      r_abort <= 1'b0;
`endif
      unique case (r_state)
        S_IDLE: begin
          if (w_acc) begin
            r_s[0]  <= bus.in_score;
            r_opt   <= bus.in_opt;
            r_a     <= bus.in_a;
            r_b     <= bus.in_b;
            r_cnt   <= 4'd1;
            r_state <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (w_acc) begin
            r_s[r_cnt[2:0]] <= bus.in_score;
            if (r_cnt == 4'd6) begin
              r_cnt      <= '0;
              r_in_ready <= 1'b0;
              r_state    <= S_EXEC;
            end else begin
              r_cnt <= r_cnt + 4'd1;
            end
          end
`ifdef CC_SEQ_ABORT_EN
          // in_ready is high here, so no accept means no valid
          else begin
            r_cnt   <= '0;
            r_abort <= 1'b1;
            r_state <= S_IDLE;
          end
`endif
        end
        S_EXEC: begin
          if (r_cnt == LP_EXEC_LAST) begin
            r_ids       <= cc_id_flat;
            r_res       <= cc_out;
            r_out_id    <= cc_id_flat[2:0];
            r_out_last  <= 1'b0;
            r_rank      <= '0;
            r_cnt       <= '0;
            r_out_valid <= 1'b1;
            r_state     <= S_DRAIN;
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        S_DRAIN: begin
          if (w_hs) begin
            if (r_out_last) begin
              r_out_valid <= 1'b0;
              r_out_last  <= 1'b0;
              r_in_ready  <= 1'b1;
              r_rank      <= '0;
              r_state     <= S_IDLE;
            end else begin
              r_rank     <= w_rank_nxt;
              r_out_id   <= r_ids[w_rank_nxt];
              r_out_last <= (w_rank_nxt == 3'd6);
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign cc_s_flat      = r_s;
  assign cc_opt         = r_opt;
  assign cc_a           = r_a;
  assign cc_b           = r_b;
  assign bus.in_ready   = r_in_ready;
  assign bus.out_valid  = r_out_valid;
  assign bus.out_id     = r_out_id;
  assign bus.out_result = r_res;
  assign bus.out_last   = r_out_last;

`ifdef CC_SEQ_ABORT_EN
  assign abort_err = r_abort;
`else
  assign abort_err = 1'b0;
`endif

endmodule

// File: tb/tb_cc_seq_ctrl.sv
// Bench for cc_seq_ctrl: frame table plus scoreboard on the id stream.
// Hand sequences cover gaps, backpressure and reset during drain.
module tb_cc_seq_ctrl;

  localparam int EXEC = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [27:0] cc_s_flat;
  logic [2:0]  cc_opt;
  logic [1:0]  cc_a;
  logic [2:0]  cc_b;
  logic [20:0] cc_id_flat;
  logic [2:0]  cc_out;
  logic        abort_err;

  cc_seq_if bus();

  cc_seq_ctrl #(.EXEC_CYCLES(EXEC)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .cc_s_flat  (cc_s_flat),
    .cc_opt     (cc_opt),
    .cc_a       (cc_a),
    .cc_b       (cc_b),
    .cc_id_flat (cc_id_flat),
    .cc_out     (cc_out),
    .abort_err  (abort_err)
  );

  always #5 clk = ~clk;

  // sc lists scores in stream order, beat 0 in the top nibble
  typedef struct packed {
    logic [27:0] sc;
    logic [2:0]  opt;
    logic [1:0]  a;
    logic [2:0]  b;
    logic [20:0] ids;
    logic [2:0]  res;
    logic [27:0] exp_s;
  } vec_t;

  typedef struct packed {
    logic [2:0] id;
    logic [2:0] res;
    logic       last;
  } exp_t;

  vec_t tbl [4];
  exp_t q [$];
  int   n_chk = 0;
  int   n_fail = 0;

  function automatic void check(string nm,
                                logic [31:0] act,
                                logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (!rst && bus.out_valid) begin
      if (q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL extra_beat: got id %0d expected none",
                 bus.out_id);
      end else begin
        check("out_id", 32'(bus.out_id), 32'(q[0].id));
        check("out_result", 32'(bus.out_result),
              32'(q[0].res));
        check("out_last", 32'(bus.out_last),
              32'(q[0].last));
        check("in_ready_drain", 32'(bus.in_ready), 0);
        if (bus.out_ready) void'(q.pop_front());
      end
    end
  end

  task automatic check_reset();
    check("rst_in_ready", 32'(bus.in_ready), 1);
    check("rst_out_valid", 32'(bus.out_valid), 0);
    check("rst_out_id", 32'(bus.out_id), 0);
    check("rst_out_last", 32'(bus.out_last), 0);
    check("rst_out_result", 32'(bus.out_result), 0);
    check("rst_abort", 32'(abort_err), 0);
    check("rst_s_flat", 32'(cc_s_flat), 0);
    check("rst_opt", 32'(cc_opt), 0);
  endtask

  task automatic load_exec(input vec_t v, input int gap);
    logic [20:0] ids;
    check("in_ready_idle", 32'(bus.in_ready), 1);
    for (int i = 0; i < 7; i++) begin
      if (gap > 0 && i == gap) begin
        bus.in_valid = 1'b0;
        for (int g = 0; g < 3; g++) begin
          tick();
          check("gap_abort", 32'(abort_err), 0);
          check("gap_ready", 32'(bus.in_ready), 1);
        end
      end
      bus.in_valid = 1'b1;
      bus.in_score = v.sc[27-4*i -: 4];
      bus.in_opt   = (i == 0) ? v.opt : ~v.opt;
      bus.in_a     = (i == 0) ? v.a : ~v.a;
      bus.in_b     = (i == 0) ? v.b : ~v.b;
      tick();
    end
    bus.in_valid = 1'b0;
    ids = v.ids;
    for (int k = 0; k < 7; k++)
      q.push_back('{id: ids[3*k +: 3], res: v.res,
                    last: (k == 6)});
    check("in_ready_exec", 32'(bus.in_ready), 0);
    check("s_flat", 32'(cc_s_flat), 32'(v.exp_s));
    check("cc_opt", 32'(cc_opt), 32'(v.opt));
    check("cc_a", 32'(cc_a), 32'(v.a));
    check("cc_b", 32'(cc_b), 32'(v.b));
    // only the last exec cycle carries the real core answer
    for (int k = 1; k <= EXEC; k++) begin
      check("valid_early", 32'(bus.out_valid), 0);
      cc_id_flat = (k == EXEC) ? v.ids : ~v.ids;
      cc_out     = (k == EXEC) ? v.res : ~v.res;
      tick();
    end
    check("valid_latency", 32'(bus.out_valid), 1);
  endtask

  task automatic drain_all();
    bus.out_ready = 1'b1;
    for (int t = 0; t < 40 && q.size() != 0; t++)
      tick();
    check("drain_empty", 32'(q.size()), 0);
    check("ready_back", 32'(bus.in_ready), 1);
    check("valid_low", 32'(bus.out_valid), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    tbl[0] = '{sc: 28'h0123456, opt: 3'd5, a: 2'd2,
               b: 3'd3, ids: 21'o0123456, res: 3'd4,
               exp_s: 28'h6543210};
    tbl[1] = '{sc: 28'hFEDCBA9, opt: 3'd7, a: 2'd3,
               b: 3'd7, ids: 21'o6543210, res: 3'd7,
               exp_s: 28'h9ABCDEF};
    tbl[2] = '{sc: 28'h3141592, opt: 3'd0, a: 2'd0,
               b: 3'd0, ids: 21'o3102546, res: 3'd1,
               exp_s: 28'h2951413};
    tbl[3] = '{sc: 28'h800000F, opt: 3'd2, a: 2'd1,
               b: 3'd4, ids: 21'o7777777, res: 3'd0,
               exp_s: 28'hF000008};

    bus.in_valid  = 1'b0;
    bus.in_score  = '0;
    bus.in_opt    = '0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.out_ready = 1'b1;
    cc_id_flat    = '0;
    cc_out        = '0;

    #2 rst = 1'b1;
    tick();
    tick();
    check_reset();
    rst = 1'b0;
    tick();

    for (int i = 0; i < 4; i++) begin
      load_exec(tbl[i], 0);
      drain_all();
    end

`ifdef CC_SEQ_ABORT_EN
    for (int i = 0; i < 3; i++) begin
      bus.in_valid = 1'b1;
      bus.in_score = tbl[1].sc[27-4*i -: 4];
      bus.in_opt   = tbl[1].opt;
      tick();
    end
    bus.in_valid = 1'b0;
    tick();
    check("abort_pulse", 32'(abort_err), 1);
    check("abort_ready", 32'(bus.in_ready), 1);
    tick();
    check("abort_once", 32'(abort_err), 0);
    check("abort_slots", 32'(cc_s_flat),
          32'({tbl[3].exp_s[27:12], 12'hDEF}));
    load_exec(tbl[2], 0);
    drain_all();
`else
    load_exec(tbl[1], 3);
    drain_all();
`endif

    load_exec(tbl[0], 0);
    tick();
    tick();
    check("bp_rank2", 32'(bus.out_id), 4);
    bus.out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      bus.in_valid = k[0];
      bus.in_score = 4'hF;
      bus.in_opt   = 3'd1;
      tick();
      check("bp_hold", 32'(bus.out_id), 4);
    end
    bus.in_valid = 1'b0;
    check("bp_s_flat", 32'(cc_s_flat), 32'(tbl[0].exp_s));
    check("bp_opt", 32'(cc_opt), 32'(tbl[0].opt));
    drain_all();

    load_exec(tbl[0], 0);
    tick();
    tick();
    tick();
    check("rst_pre_id", 32'(bus.out_id), 3);
    rst = 1'b1;
    #1;
    q.delete();
    check_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    tick();
    load_exec(tbl[2], 0);
    drain_all();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
